// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external 8-bit combinational ALU between two
// requesters (R0, R1) using round-robin arbitration, one command in flight.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   rN_valid/rN_ready        command handshake (rN_ready is combinational)
//   rN_a, rN_b, rN_op, rN_sel command payload
//   rN_resp_valid/ready      response handshake
//   rN_resp_data/carry       registered ALU result and carry
//   alu_a/b/op/sel           drive the external ALU (held between commands)
//   alu_out, alu_carry       ALU result sampled at the end of EXEC
//   busy                     high whenever the FSM is not IDLE
//   grant_id                 requester owning the current/last transaction
module alu_arbiter #(
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,

  input  logic       r0_valid,
  output logic       r0_ready,
  input  logic [7:0] r0_a,
  input  logic [7:0] r0_b,
  input  logic [2:0] r0_op,
  input  logic       r0_sel,
  output logic       r0_resp_valid,
  input  logic       r0_resp_ready,
  output logic [7:0] r0_resp_data,
  output logic       r0_resp_carry,

  input  logic       r1_valid,
  output logic       r1_ready,
  input  logic [7:0] r1_a,
  input  logic [7:0] r1_b,
  input  logic [2:0] r1_op,
  input  logic       r1_sel,
  output logic       r1_resp_valid,
  input  logic       r1_resp_ready,
  output logic [7:0] r1_resp_data,
  output logic       r1_resp_carry,

  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  output logic       alu_sel,
  input  logic [7:0] alu_out,
  input  logic       alu_carry,

  output logic       busy,
  output logic       grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_q;
  logic       ptr_q;
  logic       grant_q;
  logic       busy_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [2:0] op_q;
  logic       sel_q;
  logic       r0_resp_valid_q;
  logic       r1_resp_valid_q;
  logic [7:0] r0_resp_data_q;
  logic [7:0] r1_resp_data_q;
  logic       r0_resp_carry_q;
  logic       r1_resp_carry_q;
  logic       resp_hs;

  // Accept only in IDLE; a lone valid wins, a tie goes to the pointer.
  assign r0_ready = ~rst && (state_q == IDLE) && r0_valid && (~r1_valid || ~ptr_q);
  assign r1_ready = ~rst && (state_q == IDLE) && r1_valid && (~r0_valid ||  ptr_q);

  // Response handshake of whichever requester holds the grant.
  assign resp_hs = grant_q ? (r1_resp_valid_q && r1_resp_ready)
                           : (r0_resp_valid_q && r0_resp_ready);

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      ptr_q           <= PRIO_INIT;
      grant_q         <= PRIO_INIT;
      busy_q          <= 1'b0;
      a_q             <= 8'd0;
      b_q             <= 8'd0;
      op_q            <= 3'd0;
      sel_q           <= 1'b0;
      r0_resp_valid_q <= 1'b0;
      r1_resp_valid_q <= 1'b0;
      r0_resp_data_q  <= 8'd0;
      r1_resp_data_q  <= 8'd0;
      r0_resp_carry_q <= 1'b0;
      r1_resp_carry_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (r0_ready || r1_ready) begin
            grant_q <= r1_ready;
            a_q     <= r1_ready ? r1_a   : r0_a;
            b_q     <= r1_ready ? r1_b   : r0_b;
            op_q    <= r1_ready ? r1_op  : r0_op;
            sel_q   <= r1_ready ? r1_sel : r0_sel;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          // ALU inputs have been stable all cycle; capture its result.
          if (grant_q) begin
            r1_resp_data_q  <= alu_out;
            r1_resp_carry_q <= alu_carry;
            r1_resp_valid_q <= 1'b1;
          end else begin
            r0_resp_data_q  <= alu_out;
            r0_resp_carry_q <= alu_carry;
            r0_resp_valid_q <= 1'b1;
          end
          state_q <= RESP;
        end
        RESP: begin
          if (resp_hs) begin
            r0_resp_valid_q <= 1'b0;
            r1_resp_valid_q <= 1'b0;
            ptr_q           <= ~grant_q;
            busy_q          <= 1'b0;
            state_q         <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign alu_op        = op_q;
  assign alu_sel       = sel_q;
  assign busy          = busy_q;
  assign grant_id      = grant_q;
  assign r0_resp_valid = r0_resp_valid_q;
  assign r1_resp_valid = r1_resp_valid_q;
  assign r0_resp_data  = r0_resp_data_q;
  assign r1_resp_data  = r1_resp_data_q;
  assign r0_resp_carry = r0_resp_carry_q;
  assign r1_resp_carry = r1_resp_carry_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural 8-bit ALU attached.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       r0_valid, r0_ready, r0_sel, r0_resp_valid, r0_resp_ready, r0_resp_carry;
  logic [7:0] r0_a, r0_b, r0_resp_data;
  logic [2:0] r0_op;
  logic       r1_valid, r1_ready, r1_sel, r1_resp_valid, r1_resp_ready, r1_resp_carry;
  logic [7:0] r1_a, r1_b, r1_resp_data;
  logic [2:0] r1_op;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_op;
  logic       alu_sel, alu_carry, busy, grant_id;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.PRIO_INIT(1'b0)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
    .r0_op(r0_op), .r0_sel(r0_sel), .r0_resp_valid(r0_resp_valid),
    .r0_resp_ready(r0_resp_ready), .r0_resp_data(r0_resp_data), .r0_resp_carry(r0_resp_carry),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
    .r1_op(r1_op), .r1_sel(r1_sel), .r1_resp_valid(r1_resp_valid),
    .r1_resp_ready(r1_resp_ready), .r1_resp_data(r1_resp_data), .r1_resp_carry(r1_resp_carry),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .busy(busy), .grant_id(grant_id)
  );

  // ALU: 0 add,1 sub,2 and,3 or,4 rol,5 ror,6 shl,7 shr; sel picks b for shifts/rotates.
  logic [8:0] sum9;
  logic [7:0] opnd;
  always_comb begin
    opnd      = alu_sel ? alu_b : alu_a;
    sum9      = 9'(alu_a) + 9'(alu_b);
    alu_carry = 1'b0;
    case (alu_op)
      3'd0: begin alu_out = sum9[7:0]; alu_carry = sum9[8]; end
      3'd1: alu_out = alu_a - alu_b;
      3'd2: alu_out = alu_a & alu_b;
      3'd3: alu_out = alu_a | alu_b;
      3'd4: alu_out = {opnd[6:0], opnd[7]};
      3'd5: alu_out = {opnd[0], opnd[7:1]};
      3'd6: alu_out = {opnd[6:0], 1'b0};
      default: alu_out = {1'b0, opnd[7:1]};
    endcase
  end

  typedef struct packed {
    logic       req;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       sel;
    logic [7:0] exp_d;
    logic       exp_c;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic req, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic sel);
    if (req) begin r1_a = a; r1_b = b; r1_op = op; r1_sel = sel; r1_valid = 1'b1; end
    else     begin r0_a = a; r0_b = b; r0_op = op; r0_sel = sel; r0_valid = 1'b1; end
  endtask

  // Single transaction: accept, one EXEC cycle, response, handshake.
  task automatic do_txn(input vec_t v);
    set_cmd(v.req, v.a, v.b, v.op, v.sel);
    #1;
    chk("ready_same_cycle", v.req ? r1_ready : r0_ready, 1);
    tick();
    r0_valid = 1'b0; r1_valid = 1'b0;
    chk("exec_busy", busy, 1);
    chk("exec_alu_a", alu_a, v.a);
    chk("exec_no_resp", v.req ? r1_resp_valid : r0_resp_valid, 0);
    tick();
    chk("resp_valid", v.req ? r1_resp_valid : r0_resp_valid, 1);
    chk("other_resp_valid", v.req ? r0_resp_valid : r1_resp_valid, 0);
    chk("resp_data", v.req ? r1_resp_data : r0_resp_data, v.exp_d);
    chk("resp_carry", v.req ? r1_resp_carry : r0_resp_carry, v.exp_c);
    chk("grant_id", grant_id, v.req);
    if (v.req) r1_resp_ready = 1'b1; else r0_resp_ready = 1'b1;
    tick();
    r0_resp_ready = 1'b0; r1_resp_ready = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_resp_valid", r0_resp_valid | r1_resp_valid, 0);
  endtask

  vec_t vecs[10];
  logic winners[4];
  int   resp_cyc[4];
  logic exp_win[4];
  int   exp_cyc[4];
  int   nacc, nresp;

  initial begin
    rst = 1'b1;
    r0_valid = 0; r0_a = 0; r0_b = 0; r0_op = 0; r0_sel = 0; r0_resp_ready = 0;
    r1_valid = 0; r1_a = 0; r1_b = 0; r1_op = 0; r1_sel = 0; r1_resp_ready = 0;

    //            req op    a      b      sel  data   carry
    vecs[0] = '{1'b0, 3'd0, 8'hF0, 8'h20, 1'b0, 8'h10, 1'b1};
    vecs[1] = '{1'b1, 3'd1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0};
    vecs[2] = '{1'b1, 3'd6, 8'h00, 8'h81, 1'b1, 8'h02, 1'b0};
    vecs[3] = '{1'b0, 3'd2, 8'hAC, 8'hF0, 1'b0, 8'hA0, 1'b0};
    vecs[4] = '{1'b1, 3'd3, 8'h0F, 8'h30, 1'b0, 8'h3F, 1'b0};
    vecs[5] = '{1'b0, 3'd4, 8'h81, 8'h00, 1'b0, 8'h03, 1'b0};
    vecs[6] = '{1'b0, 3'd5, 8'h00, 8'h01, 1'b1, 8'h80, 1'b0};
    vecs[7] = '{1'b1, 3'd7, 8'h81, 8'h00, 1'b0, 8'h40, 1'b0};
    vecs[8] = '{1'b0, 3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[9] = '{1'b1, 3'd0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

    // Reset state
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_alu", {alu_a, alu_b, 5'(alu_op), 7'(alu_sel)}, 0);
    chk("rst_resp_valid", {r0_resp_valid, r1_resp_valid}, 0);
    chk("rst_resp_data", {r0_resp_data, r1_resp_data, 7'(r0_resp_carry), 1'(r1_resp_carry)}, 0);
    chk("rst_ready", {r0_ready, r1_ready}, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) do_txn(vecs[i]);

    // Round robin from reset with both requesters continuously valid
    rst = 1'b1;
    tick();
    set_cmd(1'b0, 8'h01, 8'h01, 3'd0, 1'b0);
    set_cmd(1'b1, 8'h0F, 8'h3C, 3'd2, 1'b0);
    r0_resp_ready = 1'b1; r1_resp_ready = 1'b1;
    rst = 1'b0;
    nacc = 0; nresp = 0;
    exp_win[0] = 0; exp_win[1] = 1; exp_win[2] = 0; exp_win[3] = 1;
    exp_cyc[0] = 2; exp_cyc[1] = 5; exp_cyc[2] = 8; exp_cyc[3] = 11;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if ((r0_ready || r1_ready) && nacc < 4) begin winners[nacc] = r1_ready; nacc++; end
      if ((r0_resp_valid || r1_resp_valid) && nresp < 4) begin resp_cyc[nresp] = c; nresp++; end
    end
    r0_valid = 0; r1_valid = 0;
    tick();
    r0_resp_ready = 0; r1_resp_ready = 0;
    chk("rr_accept_count", nacc, 4);
    chk("rr_resp_count", nresp, 4);
    for (int k = 0; k < 4; k++) begin
      if (k < nacc)  chk("rr_winner", winners[k], exp_win[k]);
      if (k < nresp) chk("rr_resp_cycle", resp_cyc[k], exp_cyc[k]);
    end

    // Backpressure: R0 stalls in RESP while R1 waits
    set_cmd(1'b0, 8'h33, 8'h44, 3'd0, 1'b0);
    #1 chk("bp_r0_ready", r0_ready, 1);
    tick();
    r0_valid = 0;
    set_cmd(1'b1, 8'h0F, 8'hF0, 3'd3, 1'b0);
    #1 chk("bp_r1_ready_exec", r1_ready, 0);
    tick();
    for (int k = 0; k < 10; k++) begin
      chk("bp_resp_valid", r0_resp_valid, 1);
      chk("bp_resp_data", r0_resp_data, 8'h77);
      chk("bp_r1_ready", r1_ready, 0);
      if (k == 5) begin r1_a = 8'hAA; #1; r1_a = 8'h0F; end
      tick();
    end
    r0_resp_ready = 1'b1;
    tick();
    r0_resp_ready = 1'b0;
    chk("bp_r1_ready_after", r1_ready, 1);
    tick();
    r1_valid = 0;
    chk("bp_r1_grant", grant_id, 1);
    chk("bp_r1_busy", busy, 1);
    tick();
    chk("bp_r1_data", r1_resp_data, 8'hFF);
    chk("bp_r1_carry", r1_resp_carry, 0);
    r1_resp_ready = 1'b1;
    tick();
    r1_resp_ready = 1'b0;

    // Reset during EXEC of an R1 rotate-right
    set_cmd(1'b1, 8'h03, 8'h00, 3'd5, 1'b0);
    tick();
    r1_valid = 0;
    chk("rex_alu_op", alu_op, 3'd5);
    rst = 1'b1;
    #1;
    chk("rex_busy", busy, 0);
    chk("rex_grant", grant_id, 0);
    chk("rex_alu", {alu_a, 5'(alu_op)}, 0);
    chk("rex_resp", {r1_resp_valid, r1_resp_data}, 0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rex_no_resp", r1_resp_valid, 0);
    end
    do_txn('{1'b1, 3'd5, 8'h03, 8'h00, 1'b0, 8'h81, 1'b0});

    // Pointer flip: simultaneous request right after an R0 response goes to R1
    do_txn('{1'b0, 3'd2, 8'hFF, 8'h0F, 1'b0, 8'h0F, 1'b0});
    set_cmd(1'b0, 8'h01, 8'h02, 3'd3, 1'b0);
    set_cmd(1'b1, 8'h10, 8'h01, 3'd1, 1'b0);
    #1;
    chk("flip_r1_ready", r1_ready, 1);
    chk("flip_r0_ready", r0_ready, 0);
    tick();
    r1_valid = 0;
    chk("flip_grant1", grant_id, 1);
    chk("flip_r0_ready_exec", r0_ready, 0);
    tick();
    chk("flip_r1_data", r1_resp_data, 8'h0F);
    r1_resp_ready = 1'b1;
    tick();
    r1_resp_ready = 1'b0;
    chk("flip_r0_ready_next", r0_ready, 1);
    tick();
    r0_valid = 0;
    chk("flip_grant0", grant_id, 0);
    tick();
    chk("flip_r0_data", r0_resp_data, 8'h03);
    chk("flip_r0_carry", r0_resp_carry, 0);
    r0_resp_ready = 1'b1;
    tick();
    r0_resp_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares a single 8-bit combinational ALU between two independent requesters (R0, R1).
- ALU op encoding: add, sub, and, or, rotate-left, rotate-right, shift-left, shift-right, plus a 1-bit operand-select input.
- Each requester issues a command (operands, op, select) on a valid/ready handshake and receives the registered result and carry on a response valid/ready handshake.
- Round-robin arbitration with one command in flight; the block owns the ALU input ports and samples the ALU outputs.

Parameters:
- PRIO_INIT, 0, requester that holds priority after reset (0 or 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- r0_valid  in  1  R0 command valid.
- r0_ready  out  1  R0 command accepted when r0_valid & r0_ready.
- r0_a  in  8  R0 operand A.
- r0_b  in  8  R0 operand B.
- r0_op  in  3  R0 ALU op code.
- r0_sel  in  1  R0 operand select for shift/rotate ops.
- r0_resp_valid  out  1  R0 result valid.
- r0_resp_ready  in  1  R0 result consumed when r0_resp_valid & r0_resp_ready.
- r0_resp_data  out  8  R0 result.
- r0_resp_carry  out  1  R0 carry.
- r1_*  same set as r0_*, for requester R1.
- alu_a  out  8  ALU operand A.
- alu_b  out  8  ALU operand B.
- alu_op  out  3  ALU op code.
- alu_sel  out  1  ALU select.
- alu_out  in  8  ALU result, combinational from alu_* outputs.
- alu_carry  in  1  ALU carry; 0 for every op except add.
- busy  out  1  high whenever state is not IDLE.
- grant_id  out  1  requester owning the current or last transaction.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; priority pointer = PRIO_INIT; grant_id = PRIO_INIT.
  - All ready, resp_valid, resp_data, resp_carry, busy = 0.
  - alu_a, alu_b, alu_op, alu_sel = 0.
  - Reset mid-transaction drops the command and its result silently; no response is produced after reset.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - rN_ready is combinational: r0_ready = 1 when r0_valid & (~r1_valid | pointer==0); r1_ready is symmetric. At most one ready is high per cycle, and ready is never high outside IDLE.
  - On accept, latch a, b, op, sel into operand registers, set grant_id = winner, go to EXEC.
  - Only one requester valid: that requester wins regardless of the pointer.
- EXEC (exactly one cycle):
  - alu_* driven from the operand registers, which are stable for the whole cycle.
  - At the clock edge, capture alu_out into resp_data and alu_carry into resp_carry; go to RESP.
- RESP:
  - resp_valid asserted only on the granted requester; the other requester's resp_valid = 0.
  - resp_data and resp_carry hold stable until the handshake completes.
  - On resp handshake: pointer = ~grant_id (other requester gets priority), go to IDLE.
- Latency and throughput:
  - Accept at edge N -> resp_valid high in the cycle after edge N+1, i.e. 2 cycles to first response.
  - Back-to-back throughput is 1 transaction per 3 cycles when resp_ready is held high.
- ALU ports hold their last operand values in IDLE and RESP; there is no re-drive to 0.
- Backpressure: resp_ready held low stalls in RESP indefinitely. A pending valid on either requester is not accepted during the stall and is never lost.
- Requesters must hold valid and payload stable until ready. Payload changes while not accepted are ignored.
- Starvation-free: with both requesters continuously valid, grants alternate R0, R1, R0, ... starting from PRIO_INIT.
- No arithmetic in this block. Result width rules are the ALU's; the carry is passed through unchanged.

Test Plan:
- Reset then R0 add a=8'hF0, b=8'h20 -> r0_ready high same cycle; r0_resp_valid 2 cycles later with data 8'h10, carry 1; r1_resp_valid stays 0.
- R1 sub a=8'h05, b=8'h07 -> data 8'hFE, carry 0; R1 shift-left sel=1, b=8'h81 -> data 8'h02, carry 0 (carry is add-only).
- Both valid continuously with PRIO_INIT=0, resp_ready=1 -> grant_id sequence 0,1,0,1 and one response every 3 cycles.
- R0 in RESP with r0_resp_ready=0 for 10 cycles while r1_valid=1 -> r0_resp_data stable, r1_ready=0 throughout; release -> R1 accepted the next cycle.
- Assert rst during EXEC of an R1 rotate-right -> outputs cleared immediately; after reset release, no r1_resp_valid appears and the next R1 command completes normally.
- R0 and R1 valid in the same cycle right after the R0 response -> R1 wins (pointer flipped); R0 is served on the following transaction.
